// File: rtl/fa_4bit_resp_checker_pkg.sv
// -----------------------------------------------------------------------------
// fa_chk_pkg
// Shared definitions for the 4-bit adder response checker:
//   - default operand width and counter width
//   - operand-space size (2^(2*WIDTH) operand pairs)
//   - checker state enum (IDLE / CHECK / DONE)
// Optional build macro used by the checker: FA_CHK_COVERAGE_EN.
// -----------------------------------------------------------------------------
package fa_chk_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_SPACE = 1 << (2 * DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Number of (A,B) operand pairs for a given operand width.
    function automatic int space_size(input int width);
        return 1 << (2 * width);
    endfunction

endpackage

// File: rtl/fa_4bit_resp_checker_if.sv
// -----------------------------------------------------------------------------
// fa_chk_if
// Bundles one applied adder vector: the operands driven into the adder and
// the adder's response.
//   in_valid  : qualifies all other fields this cycle
//   in_a/in_b : operands applied to the adder (WIDTH bits)
//   in_cin    : carry-in applied to the adder
//   dut_sum   : adder Sum (WIDTH bits)
//   dut_cout  : adder Cout
// Handshake: valid-only. A vector transfers on every clock edge where
// in_valid=1; there is no ready, the checker never back-pressures, and the
// master must hold nothing beyond the cycle it asserts in_valid.
// Modports: master (stimulus side, drives everything), slave (checker).
// -----------------------------------------------------------------------------
interface fa_chk_if
    import fa_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, dut_sum, dut_cout
    );

    modport slave (
        input in_valid, in_a, in_b, in_cin, dut_sum, dut_cout
    );
endinterface

// File: rtl/fa_4bit_resp_checker_ref_model.sv
// -----------------------------------------------------------------------------
// fa_ref_model
// Combinational golden adder: {cout, sum} = a + b + cin at WIDTH+1 bits.
// Ports:
//   a, b : WIDTH-bit operands (in)
//   cin  : carry-in (in)
//   sum  : WIDTH-bit sum (out)
//   cout : carry-out (out)
// -----------------------------------------------------------------------------
module fa_ref_model
    import fa_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

    assign sum  = total[WIDTH-1:0];
    assign cout = total[WIDTH];
endmodule

// File: rtl/fa_4bit_resp_checker.sv
// -----------------------------------------------------------------------------
// fa_4bit_resp_checker
// Response checker for the ripple adder sweep. Each vector accepted in CHECK
// is compared against a golden adder; vectors and mismatches are counted
// (saturating), the first failing vector is captured, and the run ends in
// DONE once the operand space is considered complete.
// Build macro: FA_CHK_COVERAGE_EN
//   defined   -> completion = every (A,B) pair seen at least once (bitmap)
//   undefined -> completion = vec_cnt reaches 2^(2*WIDTH)
// Ports:
//   clk, rst_n (sync, active-low), start (1-cycle pulse, clears and runs)
//   bus        : fa_chk_if.slave, applied operands + adder response
//   busy/done/pass, vec_cnt/err_cnt, fail_valid + fail_* record
//   state      : current FSM state, for observation
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module fa_4bit_resp_checker
    import fa_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    fa_chk_if.slave          bus,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH-1:0] fail_sum,
    output logic             fail_cout,
    output state_e           state
);
    localparam int               SPACE   = space_size(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             chk;
    logic             mismatch;
    logic [CNT_W-1:0] vec_inc;
    logic             complete;

    fa_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .cin  (bus.in_cin),
        .sum  (exp_sum),
        .cout (exp_cout)
    );

    // start has priority: a vector in the same cycle as start is dropped.
    assign chk      = (state_q == CHECK) && bus.in_valid && !start;
    assign mismatch = (bus.dut_sum != exp_sum) || (bus.dut_cout != exp_cout);
    assign vec_inc  = (vec_cnt == CNT_MAX) ? vec_cnt : vec_cnt + 1'b1;

`ifdef FA_CHK_COVERAGE_EN
    logic [SPACE-1:0] cov_q;
    logic [SPACE-1:0] cov_hit;

    always_comb begin
        cov_hit = '0;
        cov_hit[{bus.in_a, bus.in_b}] = 1'b1;
    end

    // Completion looks at the bitmap including this cycle's pair.
    assign complete = chk && (&(cov_q | cov_hit));

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            cov_q <= '0;
        end else if (chk) begin
            cov_q <= cov_q | cov_hit;
        end
    end
`else
    // Completion looks at the count including this cycle's vector.
    assign complete = chk && (vec_inc == CNT_W'(SPACE));
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK: begin
                if (start)         state_d = CHECK;
                else if (complete) state_d = DONE;
            end
            DONE:    if (start) state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    // Statistics and first-failure record
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            vec_cnt    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_sum   <= '0;
            fail_cout  <= 1'b0;
        end else if (chk) begin
            vec_cnt <= vec_inc;
            if (mismatch) begin
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_a     <= bus.in_a;
                    fail_b     <= bus.in_b;
                    fail_cin   <= bus.in_cin;
                    fail_sum   <= bus.dut_sum;
                    fail_cout  <= bus.dut_cout;
                end
            end
        end
    end

    assign busy  = (state_q == CHECK);
    assign done  = (state_q == DONE);
    assign pass  = (state_q == DONE) && (err_cnt == '0);
    assign state = state_q;
endmodule

// File: doc/fa_4bit_resp_checker.md
# fa_4bit_resp_checker

Synthesizable response checker for the 4-bit ripple adder (`FA_4bit`). It is the receiving end of the exhaustive operand sweep that drives the adder. It samples each applied operand pair together with the adder's `Sum`/`Cout` and compares them against a golden sum. It counts vectors and mismatches, captures the first failing vector, and declares pass/fail once the full 16×16 operand space has been checked. It sits beside the adder in on-board self-test and in simulation benches.

## Interface
Parameters:
- `WIDTH`, 4, operand width. The operand space is 2^(2·WIDTH) pairs.
- `CNT_W`, 16, width of the vector and error counters.

Ports:
- `clk`, in, 1, single clock.
- `rst_n`, in, 1, synchronous active-low reset.
- `start`, in, 1, one-cycle pulse. Clears all statistics and enters CHECK.
- `in_valid`, in, 1, qualifies the operand and result inputs this cycle.
- `in_a`, in, WIDTH, operand A applied to the adder.
- `in_b`, in, WIDTH, operand B applied to the adder.
- `in_cin`, in, 1, carry-in applied to the adder.
- `dut_sum`, in, WIDTH, adder `Sum`.
- `dut_cout`, in, 1, adder `Cout`.
- `busy`, out, 1, high in CHECK.
- `done`, out, 1, high in DONE.
- `pass`, out, 1, high in DONE when `err_cnt`==0.
- `vec_cnt`, out, CNT_W, number of vectors checked (saturating).
- `err_cnt`, out, CNT_W, number of mismatches (saturating).
- `fail_valid`, out, 1, a first-failure record is held.
- `fail_a`, `fail_b`, out, WIDTH, operands of the first failing vector.
- `fail_cin`, out, 1, carry-in of the first failing vector.
- `fail_sum`, out, WIDTH, `Sum` of the first failing vector.
- `fail_cout`, out, 1, `Cout` of the first failing vector.

## Operation
- State machine states: IDLE, CHECK, DONE.
  - IDLE→CHECK on `start`.
  - CHECK→DONE when the completion condition holds (see Configuration).
  - DONE→CHECK on `start`.
  - `start` in CHECK restarts the run: statistics are cleared and the state stays CHECK.
- Golden model: expected = `in_a` + `in_b` + `in_cin`, computed at WIDTH+1 bits. The MSB is the expected `Cout`; the low WIDTH bits are the expected `Sum`.
- A vector is checked when `in_valid`=1 in CHECK and `start`=0:
  - `vec_cnt` increments.
  - On a mismatch of either `Sum` or `Cout`, `err_cnt` increments.
  - If `fail_valid`=0 when a mismatch occurs, all `fail_*` fields latch and `fail_valid` sets.
  - Later failures do not overwrite the captured record.
- `in_valid` is ignored in IDLE and DONE.
- `start` together with `in_valid` in the same cycle: `start` wins and that vector is dropped, not counted.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Repeated operand pairs are counted in `vec_cnt` and checked each time.

## Timing
- Reset (`rst_n`=0 at a `clk` edge) has the same effect at any point, including mid-run:
  - state=IDLE.
  - `busy`=0, `done`=0, `pass`=0.
  - `vec_cnt`=0, `err_cnt`=0.
  - `fail_valid`=0 and all `fail_*` fields=0.
  - Coverage bitmap cleared.
- Latency is 1 cycle: a vector sampled at edge N is reflected in the counters and `fail_*` fields after edge N.
- The completion check uses the updated state, so the final vector's edge moves the state to DONE. `done` and `pass` are valid the cycle after that edge.
- All outputs are registered. No combinational path from inputs to outputs.
- `start` clears statistics on the same edge at which it is sampled.

## Configuration
- `FA_CHK_COVERAGE_EN` defined:
  - A 2^(2·WIDTH)-bit bitmap indexed by {`in_a`,`in_b`} records each checked pair.
  - Completion means every bit is set; repeats do not advance completion.
- `FA_CHK_COVERAGE_EN` undefined:
  - No bitmap is built.
  - Completion means `vec_cnt` reaches 2^(2·WIDTH), regardless of which pairs were seen.

## Structure
- Shared package `fa_chk_pkg` holds:
  - the state enum (IDLE/CHECK/DONE);
  - the default WIDTH and CNT_W;
  - the operand-space-size constant 2^(2·WIDTH).
- One sub-module: `fa_ref_model`, the combinational golden adder (WIDTH-bit operands plus carry in, WIDTH-bit sum plus carry out).

## Test plan
- Correct-adder sweep: `start`, then all 256 (A,B) pairs with Cin=0 and correct outputs. Expected: `done`=1, `pass`=1, `vec_cnt`=256, `err_cnt`=0, `fail_valid`=0.
- Fault injection: force `dut_sum`=0 for A=3, B=5, and for A=9, B=9. Expected: `err_cnt`=2; `fail_a`=3, `fail_b`=5, `fail_sum`=0; `pass`=0.
- Carry check: A=15, B=1, Cin=0 with `dut_cout`=0. Expected: mismatch counted (expected Sum=0, Cout=1).
- Duplicates: 300 vectors containing repeats covering only 200 pairs.
  - With `FA_CHK_COVERAGE_EN`: stays in CHECK, `vec_cnt`=300.
  - Without it: DONE after vector 256.
- Sampling rules:
  - `start` and `in_valid` in the same cycle: the vector is not counted.
  - `in_valid` in IDLE: `vec_cnt` stays 0.
- Mid-run reset: after 100 vectors and 1 error, drive `rst_n`=0 for one edge. Expected: all outputs 0, state IDLE; a subsequent `start` and clean sweep yields `pass`=1.
